// File: rtl/dot_product_seq_if.sv
// Handshake bundle for dot_product_seq: operand stream in, multiplier link, result stream out.
// "master" is the environment side, "slave" is the sequencer itself.
interface dot_product_seq_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic             mul_start;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic             mul_ready;
  logic [15:0]      mul_m;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, mul_ready, mul_m, out_ready,
    input  in_ready, mul_start, mul_a, mul_b, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, mul_ready, mul_m, out_ready,
    output in_ready, mul_start, mul_a, mul_b, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/dot_product_seq.sv
// Dot-product sequencer: issues (a,b) pairs one at a time to an external serial multiplier
// and accumulates the returned products into a saturating sum handed off on a result handshake.
module dot_product_seq #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  dot_product_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [7:0]       a_r;
  logic [7:0]       b_r;
  logic             last_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] count_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             mul_start_r;
  logic             out_valid_r;
  logic             accept_s;
  logic             take_product_s;
  logic             take_result_s;
  logic [ACC_W:0]   acc_sum_s;

  // Carry-out of the widened sum is the overflow indicator; the value clamps to all ones.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [15:0] prod);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {{(ACC_W-15){1'b0}}, prod};
    if (sum[ACC_W]) begin
      return {1'b1, {ACC_W{1'b1}}};
    end else begin
      return sum;
    end
  endfunction

  assign acc_sum_s = sat_add(acc_r, bus.mul_m);

  // Next-state decode; mul_ready only matters while waiting for a product.
  always_comb begin
    state_s        = state_r;
    accept_s       = 1'b0;
    take_product_s = 1'b0;
    take_result_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          accept_s = 1'b1;
          state_s  = ISSUE;
        end else begin
          state_s  = IDLE;
        end
      end
      ISSUE: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (bus.mul_ready) begin
          take_product_s = 1'b1;
          state_s        = last_r ? DONE : IDLE;
        end else begin
          state_s        = WAIT;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          take_result_s = 1'b1;
          state_s       = IDLE;
        end else begin
          state_s       = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Handshake strobes registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      mul_start_r <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == IDLE);
      mul_start_r <= (state_s == ISSUE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand capture; held so the multiplier sees stable operands until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= 8'd0;
      b_r    <= 8'd0;
      last_r <= 1'b0;
    end else if (accept_s) begin
      a_r    <= bus.in_a;
      b_r    <= bus.in_b;
      last_r <= bus.in_last;
    end
  end

  // Accumulator, pair counter and sticky overflow; cleared when the result is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= {ACC_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
    end else if (take_result_s) begin
      acc_r   <= {ACC_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
    end else if (take_product_s) begin
      acc_r <= acc_sum_s[ACC_W-1:0];
      if (&count_r) begin
        count_r <= count_r;
      end else begin
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      ovf_r <= ovf_r | acc_sum_s[ACC_W] | (&count_r);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mul_start = mul_start_r;
  assign bus.mul_a     = a_r;
  assign bus.mul_b     = b_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = acc_r;
  assign bus.out_count = count_r;
  assign bus.out_ovf   = ovf_r;

endmodule
